// File: rtl/uart_rx_fifo_pkg.sv
// Shared peripheral constants: UART baud divisor, default end-of-line byte,
// and the width helpers used to size FIFO pointers and occupancy counters.
package uart_rx_fifo_pkg;

    localparam logic [15:0] UART_BAUD_DIV   = 16'd52;
    localparam logic [7:0]  LF_CHAR_DEFAULT = 8'h0A;

    // Pointers address DEPTH entries; counters must also represent DEPTH itself.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x 8 byte storage: synchronous write, asynchronous read, contents never reset.
// Latency: written byte readable the cycle after the write; no flow control of its own.
module uart_rx_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [ptr_w(DEPTH)-1:0] waddr_i,
    input  logic [7:0]              wdata_i,
    input  logic [ptr_w(DEPTH)-1:0] raddr_i,
    output logic [7:0]              rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with end-of-line counting and sticky overflow/framing flags.
// Latency 1 cycle push-to-rvalid; valid/ready on the read side, drops bytes when full.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] LF_CHAR = LF_CHAR_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    rx_received_i,
    input  logic [7:0]              rx_byte_i,
    input  logic                    rx_error_i,
    input  logic                    clear_i,
    output logic [7:0]              rdata_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [cnt_w(DEPTH)-1:0] count_o,
    output logic [cnt_w(DEPTH)-1:0] lines_o,
    output logic                    overflow_o,
    output logic                    frame_err_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d, lines_q, lines_d;
    logic          ovf_q, ovf_d, ferr_q, ferr_d;
    logic          full, push_req, push, pop, push_lf, pop_lf;

    assign full     = (count_q == CW'(DEPTH));
    assign rvalid_o = (count_q != '0);
    assign pop      = rvalid_o && rready_i && !clear_i;
    assign push_req = rx_received_i && !rx_error_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req && (!full || pop) && !clear_i;
    assign push_lf  = push && (rx_byte_i == LF_CHAR);
    assign pop_lf   = pop && (rdata_o == LF_CHAR);

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        lines_d = lines_q;
        ovf_d   = ovf_q;
        ferr_d  = ferr_q;
        if (clear_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            lines_d = '0;
            ovf_d   = 1'b0;
            ferr_d  = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case ({push_lf, pop_lf})
                2'b10:   lines_d = lines_q + CW'(1);
                2'b01:   lines_d = lines_q - CW'(1);
                default: lines_d = lines_q;
            endcase
            if (push_req && full && !pop)      ovf_d  = 1'b1;
            if (rx_received_i && rx_error_i)   ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            lines_q <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            lines_q <= lines_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push && rst_ni),
        .waddr_i (wptr_q),
        .wdata_i (rx_byte_i),
        .raddr_i (rptr_q),
        .rdata_o (rdata_o)
    );

    assign count_o     = count_q;
    assign lines_o     = lines_q;
    assign overflow_o  = ovf_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at DEPTH=16: per-cycle state checks against a
// queue model plus directed scenarios for ordering, full/empty corners, clear and reset.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          rx_received_i;
    logic [7:0]    rx_byte_i;
    logic          rx_error_i;
    logic          clear_i;
    logic [7:0]    rdata_o;
    logic          rvalid_o;
    logic          rready_i;
    logic [CW-1:0] count_o;
    logic [CW-1:0] lines_o;
    logic          overflow_o;
    logic          frame_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mq [$];
    logic       m_ovf  = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] last_pop;
    int         max_cnt;

    always #5 clk_i = ~clk_i;

    uart_rx_fifo #(
        .DEPTH   (DEPTH),
        .LF_CHAR (8'h0A)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rx_received_i (rx_received_i),
        .rx_byte_i     (rx_byte_i),
        .rx_error_i    (rx_error_i),
        .clear_i       (clear_i),
        .rdata_o       (rdata_o),
        .rvalid_o      (rvalid_o),
        .rready_i      (rready_i),
        .count_o       (count_o),
        .lines_o       (lines_o),
        .overflow_o    (overflow_o),
        .frame_err_o   (frame_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_lines();
        int n = 0;
        foreach (mq[i]) if (mq[i] == 8'h0A) n++;
        return n;
    endfunction

    // One clock cycle: drive at negedge, compare held state to the model, update model, take edge.
    task automatic step(input logic rcv, input logic [7:0] b, input logic err,
                        input logic rdy, input logic clr);
        logic pop_now, push_now;
        @(negedge clk_i);
        rx_received_i = rcv;
        rx_byte_i     = b;
        rx_error_i    = err;
        rready_i      = rdy;
        clear_i       = clr;
        #1;
        chk("count",     32'(count_o),     32'(mq.size()));
        chk("lines",     32'(lines_o),     32'(model_lines()));
        chk("rvalid",    32'(rvalid_o),    32'(mq.size() != 0));
        chk("overflow",  32'(overflow_o),  32'(m_ovf));
        chk("frame_err", 32'(frame_err_o), 32'(m_ferr));
        chk("lines_le_count", 32'(lines_o <= count_o), 32'd1);
        pop_now  = (mq.size() != 0) && rdy && !clr;
        push_now = rcv && !err && !clr && ((mq.size() < DEPTH) || pop_now);
        if (pop_now) begin
            chk("rdata", 32'(rdata_o), 32'(mq[0]));
            last_pop = rdata_o;
            void'(mq.pop_front());
        end
        if (clr) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            if (rcv && err)             m_ferr = 1'b1;
            if (rcv && !err && !push_now) m_ovf = 1'b1;
        end
        if (push_now) mq.push_back(b);
        @(posedge clk_i);
        #1;
        if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_pulse();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_ni        = 1'b0;
        rx_received_i = 1'b0;
        rx_byte_i     = 8'h00;
        rx_error_i    = 1'b0;
        clear_i       = 1'b0;
        rready_i      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_count",  32'(count_o),     32'd0);
        chk("rst_lines",  32'(lines_o),     32'd0);
        chk("rst_rvalid", 32'(rvalid_o),    32'd0);
        chk("rst_ovf",    32'(overflow_o),  32'd0);
        chk("rst_ferr",   32'(frame_err_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic ordering with an end-of-line byte.
        push(8'h41); push(8'h42); push(8'h0A);
        chk("t1_count", 32'(count_o), 32'd3);
        chk("t1_lines", 32'(lines_o), 32'd1);
        chk("t1_head",  32'(rdata_o), 32'h41);
        repeat (3) idle(1'b1);
        chk("t1_last",   32'(last_pop), 32'h0A);
        chk("t1_empty",  32'(count_o),  32'd0);
        chk("t1_lines0", 32'(lines_o),  32'd0);
        chk("t1_rvalid", 32'(rvalid_o), 32'd0);

        // Overflow: 17 bytes into 16 entries, then drain.
        for (int i = 0; i <= 16; i++) push(8'(i));
        chk("t2_count", 32'(count_o),    32'd16);
        chk("t2_ovf",   32'(overflow_o), 32'd1);
        repeat (16) idle(1'b1);
        chk("t2_last",  32'(last_pop),   32'h0F);
        chk("t2_ovf_sticky", 32'(overflow_o), 32'd1);
        clear_pulse();
        chk("t2_ovf_clr", 32'(overflow_o), 32'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("t3_ovf",   32'(overflow_o), 32'd0);
        chk("t3_count", 32'(count_o),    32'd16);
        repeat (16) idle(1'b1);
        chk("t3_last",  32'(last_pop),   32'h55);

        // Framing error on an LF byte, then flush.
        step(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0);
        chk("t4_count", 32'(count_o),     32'd0);
        chk("t4_lines", 32'(lines_o),     32'd0);
        chk("t4_ferr",  32'(frame_err_o), 32'd1);
        clear_pulse();
        chk("t4_ferr_clr", 32'(frame_err_o), 32'd0);

        // Clear takes priority over a concurrent push and pop.
        push(8'h0A); push(8'h33);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        chk("t5_count", 32'(count_o), 32'd0);
        chk("t5_lines", 32'(lines_o), 32'd0);

        // Streaming with rready held: pointers wrap, occupancy stays at most 1.
        max_cnt = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        chk("t6_maxcnt", 32'(max_cnt <= 1), 32'd1);
        chk("t6_last",   32'(last_pop),     32'(8'h80 + 39));

        // Reset mid-operation with data and overflow present.
        for (int i = 0; i <= 16; i++) push(8'(8'hC0 + i));
        repeat (11) idle(1'b1);
        chk("t7_count_pre", 32'(count_o),    32'd5);
        chk("t7_ovf_pre",   32'(overflow_o), 32'd1);
        @(negedge clk_i);
        rst_ni   = 1'b0;
        rready_i = 1'b1;
        @(posedge clk_i);
        #1;
        mq.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        chk("t7_count",  32'(count_o),    32'd0);
        chk("t7_ovf",    32'(overflow_o), 32'd0);
        chk("t7_rvalid", 32'(rvalid_o),   32'd0);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        rready_i = 1'b0;
        push(8'h99);
        idle(1'b1);
        chk("t7_post", 32'(last_pop), 32'h99);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..256.
REQ-002 Parameter LF_CHAR, default 8'h0A, byte value counted as end-of-line.
REQ-003 clk_i  in  1  single clock; every register is updated on its rising edge.
REQ-004 rst_ni  in  1  reset, synchronous and active-low.
REQ-005 rx_received_i  in  1  one-cycle pulse from the UART receiver: rx_byte_i is valid.
REQ-006 rx_byte_i  in  8  received byte.
REQ-007 rx_error_i  in  1  one-cycle pulse from the UART receiver: framing error on the current byte.
REQ-008 clear_i  in  1  synchronous flush of all contents and of the sticky flags.
REQ-009 rdata_o  out  8  byte at the FIFO head.
REQ-010 rvalid_o  out  1  rdata_o is valid (FIFO not empty).
REQ-011 rready_i  in  1  consumer accepts the head byte.
REQ-012 count_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-013 lines_o  out  $clog2(DEPTH)+1  number of LF_CHAR bytes currently stored.
REQ-014 overflow_o  out  1  sticky: a byte was dropped because the FIFO was full.
REQ-015 frame_err_o  out  1  sticky: a framing error was seen.

Function
REQ-016 Push occurs when rx_received_i=1, rx_error_i=0 and the FIFO is not full; the byte is visible on rdata_o with rvalid_o=1 on the next cycle, so latency is 1 cycle.
REQ-017 Pop occurs on a cycle with rvalid_o=1 and rready_i=1; the head advances on the next edge.
REQ-018 rdata_o is read from the FIFO storage combinationally using the read pointer; no bypass from rx_byte_i to rdata_o exists.
REQ-019 rx_received_i=1 with rx_error_i=1: the byte is discarded and frame_err_o is set.
REQ-020 Push when full (count_o=DEPTH) and no pop in the same cycle: the byte is dropped, overflow_o is set, and contents are unchanged.
REQ-021 Push and pop in the same cycle when full: both occur, count_o is unchanged, overflow_o is not set.
REQ-022 Push and pop in the same cycle when empty: the pop is invalid because rvalid_o=0; the push occurs and count_o becomes 1.
REQ-023 Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH; full and empty are derived from count_o.
REQ-024 lines_o increments on a push of LF_CHAR and decrements on a pop of LF_CHAR; a simultaneous push and pop of LF_CHAR leaves it unchanged.
REQ-025 lines_o never exceeds count_o.
REQ-026 clear_i=1 for one cycle: pointers, count_o, lines_o, overflow_o and frame_err_o are 0 on the next cycle; any push or pop in that cycle is ignored.
REQ-027 clear_i has priority over push and pop; rst_ni has priority over clear_i.
REQ-028 Sticky flags are cleared only by clear_i or by reset.

Reset
REQ-029 While rst_ni=0 at a clock edge, the pointers, count_o, lines_o, overflow_o and frame_err_o are set to 0, and rvalid_o=0.
REQ-030 Storage array contents are not reset; rdata_o is don't-care while rvalid_o=0.
REQ-031 Reset asserted mid-operation discards all stored bytes, and no pop handshake completes in that cycle.

Structure
REQ-032 The LF_CHAR default and the pointer/count width helper belong in the shared peripheral package, together with the UART baud constant (16'd52).
REQ-033 One sub-module is used: uart_rx_fifo_mem, a DEPTH x 8 register array with synchronous write and asynchronous read; all control logic stays in the top module.

Verification
REQ-034 After reset, push 0x41, 0x42, 0x0A with rready_i=0: count_o=3, lines_o=1, rdata_o=0x41; pop 3 times: bytes are 0x41, 0x42, 0x0A in order, then count_o=0, lines_o=0, rvalid_o=0.
REQ-035 DEPTH=16, push 17 bytes 0x00..0x10 with no pops: count_o=16, overflow_o=1; 16 pops return 0x00..0x0F.
REQ-036 FIFO full plus simultaneous push 0x55 and pop: overflow_o stays 0, count_o=16, and 0x55 is read last.
REQ-037 rx_received_i with rx_error_i and byte 0x0A: count_o=0, lines_o=0, frame_err_o=1; then clear_i pulse: frame_err_o=0.
REQ-038 Stream 40 bytes with rready_i held at 1: pointers wrap twice, output order matches input, and count_o never exceeds 1.
REQ-039 Assert rst_ni=0 with count_o=5 and overflow_o=1: next cycle count_o=0, overflow_o=0, rvalid_o=0.
